// File: rtl/tff_stream_decoder_if.sv
// Output word stream of the toggle flip-flop link decoder.
// The decoder is the master (drives data/valid); the consumer is the slave (drives ready).
interface tff_stream_decoder_if #(
  parameter int W = 8
);
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/tff_stream_decoder.sv
// Recovers the toggle stream T from samples of a toggle flip-flop's Q output.
// Each bit is T = Q(now) ^ Q(previous sample), and bits are packed LSB-first into W-bit words.
// The first valid sample after reset or resync only primes the previous-Q register.
// A completed word that cannot be handed over is dropped, and a sticky overflow flag records it.
module tff_stream_decoder #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 q_in,
  input  logic                 q_valid,
  input  logic                 resync,
  tff_stream_decoder_if.master out_if,
  output logic                 overflow,
  output logic [15:0]          toggle_cnt
);

  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state_q;
  logic           q_prev_q;
  logic [CW-1:0]  bit_cnt_q;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   out_data_q;
  logic           out_valid_q;
  logic           overflow_q;
  logic [15:0]    toggle_cnt_q;

  logic           sample_run;
  logic           t_bit;
  logic           word_done;
  logic [W-1:0]   sr_d;

  // A sample becomes a bit only in RUN, and a resync in the same cycle discards it
  assign sample_run = q_valid && !resync && (state_q == RUN);
  assign t_bit      = q_in ^ q_prev_q;
  assign word_done  = sample_run && (bit_cnt_q == CW'(W - 1));

  // Shift register with the current bit inserted; on the last bit this is the finished word
  always_comb begin
    sr_d            = sr_q;
    sr_d[bit_cnt_q] = t_bit;
  end

  // Decoder FSM, bit assembly, toggle counter and output word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      q_prev_q     <= 1'b0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      toggle_cnt_q <= '0;
    end else begin
      if (resync) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        sr_q      <= '0;
      end else if (q_valid) begin
        q_prev_q <= q_in;
        if (state_q == IDLE) begin
          state_q <= RUN;
        end else begin
          sr_q      <= sr_d;
          bit_cnt_q <= word_done ? '0 : bit_cnt_q + CW'(1);
          if (t_bit && (toggle_cnt_q != 16'hFFFF)) begin
            toggle_cnt_q <= toggle_cnt_q + 16'd1;
          end
        end
      end

      if (word_done) begin
        if (!out_valid_q || out_if.out_ready) begin
          out_data_q  <= sr_d;
          out_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (out_valid_q && out_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign overflow         = overflow_q;
  assign toggle_cnt       = toggle_cnt_q;

endmodule

// File: doc/tff_stream_decoder.md
TFF_STREAM_DECODER -- requirements
Module: tff_stream_decoder

Interface
REQ-001 Parameter: W, default 8, recovered-word width in bits (W >= 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 q_in  input  1  sampled Q of a toggle flip-flop link.
REQ-005 q_valid  input  1  strobe; q_in is a valid sample this cycle.
REQ-006 resync  input  1  synchronous request to drop the partial word and re-prime.
REQ-007 out_data  output  W  recovered toggle word, LSB = first bit.
REQ-008 out_valid  output  1  out_data holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-010 overflow  output  1  sticky; a completed word was dropped.
REQ-011 toggle_cnt  output  16  saturating count of recovered T=1 bits.

Function
REQ-012 FSM has two states, IDLE and RUN, with internal q_prev, bit_cnt (0..W-1) and shift register sr[W-1:0].
REQ-013 In IDLE, a cycle with q_valid=1 shall capture q_prev<=q_in, emit no bit, and move to RUN.
REQ-014 In RUN, a cycle with q_valid=1 shall form t=q_in^q_prev, update q_prev<=q_in, write t into sr[bit_cnt], and increment bit_cnt.
REQ-015 Cycles with q_valid=0 shall leave q_prev, sr, bit_cnt, toggle_cnt and the FSM state unchanged.
REQ-016 A RUN sample with bit_cnt=W-1 completes a word {t, sr[W-2:0]}, and bit_cnt shall wrap to 0 whether or not the word is kept.
REQ-017 A completed word shall load out_data and set out_valid on the next edge when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-018 If a word completes while out_valid=1 and out_ready=0, the word shall be discarded, out_data held, and overflow set to 1 until rst.
REQ-019 A handshake with out_valid=1, out_ready=1 and no completing word shall clear out_valid on the next edge; out_data keeps its last value.
REQ-020 out_data shall be stable while out_valid=1 and out_ready=0.
REQ-021 Latency: out_valid rises on the edge after the cycle with the completing sample.
REQ-022 toggle_cnt shall increment by 1 for each RUN sample with t=1 and saturate at 0xFFFF, never wrapping.
REQ-023 resync=1 shall move the FSM to IDLE and clear bit_cnt and sr; out_data, out_valid, overflow and toggle_cnt are unaffected.
REQ-024 resync=1 together with q_valid=1 shall discard the sample: no q_prev capture, no bit, no count; the FSM ends in IDLE.
REQ-025 A handshake occurring in the same cycle as resync shall still be honoured per REQ-019.

Reset
REQ-026 rst=1 takes priority over all inputs, including resync.
REQ-027 On rst=1 the block shall set state=IDLE, q_prev=0, bit_cnt=0, sr=0, out_data=0, out_valid=0, overflow=0, toggle_cnt=0.
REQ-028 rst asserted mid-word or with out_valid=1 shall discard all pending data.

Verification (W=8)
REQ-029 rst=1 for 2 cycles, then 0 -> out_valid=0, out_data=0x00, overflow=0, toggle_cnt=0.
REQ-030 Prime q=0, then samples q=1,1,0,0,0,1,0,1 with out_ready=1 -> one word out_data=0xE5, out_valid for 1 cycle after the 8th sample, toggle_cnt=5.
REQ-031 out_ready=0, feed prime plus 16 samples -> first word held unchanged, second word dropped, overflow=1, out_valid stays 1.
REQ-032 Word completes in the same cycle as an out_ready handshake on a prior word -> new word loaded, out_valid remains 1, overflow=0.
REQ-033 Prime plus 3 samples, then resync, then prime q=0 plus 8 samples all q=0 -> out_data=0x00; toggle_cnt equals the toggles counted before resync.
REQ-034 Prime plus 70000 alternating samples -> toggle_cnt=0xFFFF and holds; resync plus q_valid in the same cycle -> FSM in IDLE, count unchanged.
